// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the UART byte arbiter: controller state encoding,
// UART register map and status-register bit positions.
package uart_arb_pkg;

  // Controller states. Each INIT_* state issues one configuration write.
  // IDLE waits for a requester.
  // SEND, POLL_RE and POLL_CHK move one byte out and wait for the
  // transmitter to finish with it.
  typedef enum logic [2:0] {
    INIT_DR  = 3'd0,
    INIT_CR  = 3'd1,
    IDLE     = 3'd2,
    SEND     = 3'd3,
    POLL_RE  = 3'd4,
    POLL_CHK = 3'd5
  } state_t;

  // UART register map (byte addresses on the simple register interface).
  localparam logic [7:0] UART_CR_A = 8'h00;  // control: bit0 = tx_en
  localparam logic [7:0] UART_TX_A = 8'h04;  // transmit data
  localparam logic [7:0] UART_SR_A = 8'h08;  // status
  localparam logic [7:0] UART_DR_A = 8'h0C;  // baud divider

  // Status register: transmitter still shifting the previous byte.
  localparam int SR_TX_BUSY = 0;

  // Control word that enables the transmitter.
  localparam logic [31:0] CR_TX_EN = 32'h0000_0001;

endpackage

// File: rtl/uart_arb_rr.sv
// uart_arb_rr
// Combinational round-robin picker. The search starts one position after
// the previous grant and wraps, so the previous grant has the lowest priority.
//
// Ports:
//   req   in  NREQ  request vector
//   last  in  GW    index of the previous grant
//   grant out GW    selected index (equals last when nothing is requested)
//   any   out 1     at least one request bit is set
module uart_arb_rr #(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last,
  output logic [GW-1:0]   grant,
  output logic            any
);

  always_comb begin
    int idx;
    idx   = 0;
    grant = last;
    any   = 1'b0;
    // Walk from the farthest candidate (last itself) to the nearest
    // (last+1). A later hit overrides an earlier one, so the nearest set
    // bit after last wins.
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) begin
        grant = idx[GW-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_arb.sv
// uart_arb
// Arbitrates single bytes from NREQ requesters onto one UART through a simple
// register-interface master. After reset the block writes the baud divider
// and the control register. It then grants requesters round-robin. For each
// granted byte it writes the byte to the TX register. It then polls the
// status register until the transmitter is no longer busy.
//
// Optional feature macro: UART_ARB_LOCK_EN
//   When this macro is defined, the block has an extra req_lock input. A
//   locked requester that is still valid is granted again in place of the
//   next requester in rotation.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rstn       in   1        asynchronous active-low reset
//   req_valid  in   NREQ     per-requester byte valid
//   req_data   in   NREQ*8   per-requester byte, requester i at [8i+7:8i]
//   req_lock   in   NREQ     (UART_ARB_LOCK_EN only) hold grant on requester
//   req_ready  out  NREQ     one-cycle accept pulse, at most one bit set
//   grant_id   out  GW       index of the current/last granted requester
//   busy       out  1        high in every state except IDLE
//   addr       out  8        UART register address
//   we         out  1        UART write enable
//   wd         out  32       UART write data
//   re         out  1        UART read enable
//   rd         in   32       UART read data, valid the cycle after re
module uart_arb
  import uart_arb_pkg::*;
#(
  parameter int          NREQ     = 4,
  parameter logic [15:0] BAUD_DIV = 16'd868,
  localparam int         GW       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  output logic [NREQ-1:0]   req_ready,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic [7:0]        addr,
  output logic              we,
  output logic [31:0]       wd,
  output logic              re,
  input  logic [31:0]       rd
);

  state_t          state_reg;
  state_t          state_next;
  logic            armed_reg;   // low only for the first cycle after reset
  logic [GW-1:0]   grant_reg;
  logic [7:0]      byte_reg;

  logic [GW-1:0]   rr_grant;
  logic            rr_any;
  logic [GW-1:0]   pick;
  logic            accept;
  logic [NREQ-1:0] ready_vec;
  logic            tx_busy;

  // Only the TX-busy flag of the status word matters. The fold below keeps
  // the whole read bus connected.
  logic            unused_rd_bits;
  assign unused_rd_bits = ^rd;
  assign tx_busy        = rd[SR_TX_BUSY];

  uart_arb_rr #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_rr (
    .req   (req_valid),
    .last  (grant_reg),
    .grant (rr_grant),
    .any   (rr_any)
  );

`ifdef UART_ARB_LOCK_EN
  // A locked requester that is still valid keeps the grant. Its valid bit
  // also makes rr_any high, so accept stays correct.
  logic lock_hold;
  assign lock_hold = req_lock[grant_reg] & req_valid[grant_reg];
  assign pick      = lock_hold ? grant_reg : rr_grant;
`else
  assign pick      = rr_grant;
`endif

  assign accept = (state_reg == IDLE) && rr_any;

  // One-hot accept pulse for the chosen requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign ready_vec[gi] = accept && (pick == GW'(gi));
  end

  // State register together with the registers that hold the grant and the byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= INIT_DR;
      armed_reg <= 1'b0;
      grant_reg <= GW'(NREQ - 1);
      byte_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      armed_reg <= 1'b1;
      if (accept) begin
        grant_reg <= pick;
        byte_reg  <= req_data[{pick, 3'b000} +: 8];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      // INIT_DR is entered asynchronously with reset. Hold it for one cycle
      // after release. This places the divider write in the first full
      // clock cycle, and no bus command is driven while reset is asserted.
      INIT_DR:  state_next = armed_reg ? INIT_CR : INIT_DR;
      INIT_CR:  state_next = IDLE;
      IDLE:     state_next = rr_any ? SEND : IDLE;
      SEND:     state_next = POLL_RE;
      POLL_RE:  state_next = POLL_CHK;
      // The status word requested in POLL_RE is on rd during this cycle.
      POLL_CHK: state_next = tx_busy ? POLL_RE : IDLE;
      default:  state_next = INIT_DR;
    endcase
  end

  // Output logic. addr and wd are zero unless we or re is high.
  always_comb begin
    we        = 1'b0;
    re        = 1'b0;
    addr      = 8'h00;
    wd        = 32'h0;
    req_ready = '0;
    busy      = (state_reg != IDLE);
    case (state_reg)
      INIT_DR: begin
        if (armed_reg) begin
          we   = 1'b1;
          addr = UART_DR_A;
          wd   = {16'h0, BAUD_DIV};
        end
      end
      INIT_CR: begin
        we   = 1'b1;
        addr = UART_CR_A;
        wd   = CR_TX_EN;
      end
      IDLE: begin
        req_ready = ready_vec;
      end
      SEND: begin
        we   = 1'b1;
        addr = UART_TX_A;
        wd   = {24'h0, byte_reg};
      end
      POLL_RE: begin
        re   = 1'b1;
        addr = UART_SR_A;
      end
      default: ;
    endcase
  end

  assign grant_id = grant_reg;

endmodule
